// File: rtl/proc_run_controller.sv
// proc_run_controller
//   Sequences one processor run: hold the processor in reset, let it run
//   until it halts, is aborted or hits a cycle limit, drain for a few cycles
//   with the clock-enable low, then pulse done. All outputs are registered.
//
// Parameters
//   RESET_HOLD    cycles the processor is held in reset before a run (1..255)
//   DRAIN_CYCLES  cycles with proc_run low after a run, before done (1..255)
//
// Ports
//   clk            in   system clock, rising edge
//   RESET          in   asynchronous active-high controller reset
//   start          in   run request, sampled only in IDLE
//   start_addr     in   [31:0] processor start PC, captured on start acceptance
//   cycle_limit    in   [31:0] max RUN cycles, captured on acceptance, 0 = none
//   abort          in   terminate an in-progress run (HOLD or RUN only)
//   proc_halt      in   processor halt indication, sampled only in RUN
//   proc_reset     out  active-high reset to the processor
//   proc_start_pc  out  [31:0] start PC presented to the processor
//   proc_run       out  processor clock-enable
//   busy           out  high in every state except IDLE
//   done           out  one-cycle completion pulse
//   timeout        out  last run ended by cycle_limit (held until next start)
//   aborted        out  last run ended by abort (held until next start)
//   run_cycles     out  [31:0] cycles proc_run was high in current/last run
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start, processor held in reset
// HOLD  | RESET_HOLD cycles of processor reset with start PC presented
// RUN   | processor clock enabled, run_cycles counting
// DRAIN | DRAIN_CYCLES cycles with clock-enable low, reset released
// DONE  | single cycle with done=1, then back to IDLE

module proc_run_controller #(
    parameter int unsigned RESET_HOLD   = 4,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic [31:0] cycle_limit,
    input  logic        abort,
    input  logic        proc_halt,
    output logic        proc_reset,
    output logic [31:0] proc_start_pc,
    output logic        proc_run,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        aborted,
    output logic [31:0] run_cycles
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HOLD  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    // Down-counters are loaded with N-1 so the state lasts exactly N cycles,
    // leaving when the count reads zero.
    localparam logic [7:0] HOLD_LOAD  = 8'(RESET_HOLD - 1);
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [7:0]  tmr;
    logic [31:0] limit_q;
    logic [31:0] run_inc;
    logic        limit_hit;
    logic        run_exit;

    // Saturating increment; the limit compare uses the post-increment value
    // so the run ends after exactly cycle_limit RUN cycles.
    assign run_inc   = (run_cycles == 32'hFFFF_FFFF) ? run_cycles : run_cycles + 32'd1;
    assign limit_hit = (limit_q != 32'd0) && (run_inc == limit_q);
    assign run_exit  = abort || proc_halt || limit_hit;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = HOLD;
            HOLD: begin
                if (abort)             next_state = DONE;
                else if (tmr == 8'd0)  next_state = RUN;
            end
            RUN:     if (run_exit) next_state = DRAIN;
            DRAIN:   if (tmr == 8'd0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            tmr           <= 8'd0;
            limit_q       <= 32'd0;
            proc_reset    <= 1'b1;
            proc_start_pc <= 32'd0;
            proc_run      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            aborted       <= 1'b0;
            run_cycles    <= 32'd0;
        end else begin
            state <= next_state;

            // Outputs follow the state being entered so they line up with it.
            proc_reset <= (next_state == IDLE) || (next_state == HOLD);
            proc_run   <= (next_state == RUN);
            busy       <= (next_state != IDLE);
            done       <= (next_state == DONE);

            case (state)
                IDLE: begin
                    if (start) begin
                        proc_start_pc <= start_addr;
                        limit_q       <= cycle_limit;
                        run_cycles    <= 32'd0;
                        timeout       <= 1'b0;
                        aborted       <= 1'b0;
                        tmr           <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else if (tmr != 8'd0) begin
                        tmr <= tmr - 8'd1;
                    end
                end
                RUN: begin
                    run_cycles <= run_inc;
                    if (run_exit) begin
                        tmr <= DRAIN_LOAD;
                        if (abort) begin
                            aborted <= 1'b1;
                        end else if (!proc_halt) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (tmr != 8'd0) tmr <= tmr - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_run_controller.sv
// Testbench for proc_run_controller: directed runs, with a scoreboard of
// expected per-run results checked by a monitor on each done pulse.
module tb_proc_run_controller;

    logic        clk = 1'b0;
    logic        RESET;
    logic        start;
    logic [31:0] start_addr;
    logic [31:0] cycle_limit;
    logic        abort;
    logic        proc_halt;
    logic        proc_reset;
    logic [31:0] proc_start_pc;
    logic        proc_run;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        aborted;
    logic [31:0] run_cycles;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rc;
        logic        to;
        logic        ab;
        int          hold_n;
        int          run_n;
        int          drain_n;
    } exp_t;

    exp_t exp_q[$];

    int          hold_n  = 0;
    int          run_n   = 0;
    int          drain_n = 0;
    logic [31:0] hold_pc = 32'd0;

    proc_run_controller #(.RESET_HOLD(4), .DRAIN_CYCLES(2)) dut (
        .clk           (clk),
        .RESET         (RESET),
        .start         (start),
        .start_addr    (start_addr),
        .cycle_limit   (cycle_limit),
        .abort         (abort),
        .proc_halt     (proc_halt),
        .proc_reset    (proc_reset),
        .proc_start_pc (proc_start_pc),
        .proc_run      (proc_run),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .aborted       (aborted),
        .run_cycles    (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: counts phase lengths and compares against the scoreboard at done.
    always @(negedge clk) begin
        if (RESET) begin
            hold_n  = 0;
            run_n   = 0;
            drain_n = 0;
        end else begin
            if (busy && proc_reset) begin
                hold_n++;
                hold_pc = proc_start_pc;
            end
            if (proc_run) run_n++;
            if (busy && !proc_reset && !proc_run && !done) drain_n++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("hold_pc",    hold_pc,              e.pc);
                    check("done_pc",    proc_start_pc,        e.pc);
                    check("run_cycles", run_cycles,           e.rc);
                    check("timeout",    32'(timeout),         32'(e.to));
                    check("aborted",    32'(aborted),         32'(e.ab));
                    check("hold_len",   32'(hold_n),          32'(e.hold_n));
                    check("run_len",    32'(run_n),           32'(e.run_n));
                    check("drain_len",  32'(drain_n),         32'(e.drain_n));
                end
                hold_n  = 0;
                run_n   = 0;
                drain_n = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] rc, input logic to,
                        input logic ab, input int h, input int r, input int d);
        exp_t e;
        e.pc = pc; e.rc = rc; e.to = to; e.ab = ab;
        e.hold_n = h; e.run_n = r; e.drain_n = d;
        exp_q.push_back(e);
    endtask

    // Issue start for one cycle; returns in the first HOLD cycle.
    task automatic do_start(input logic [31:0] addr, input logic [31:0] lim, input logic ab);
        tick();
        start = 1'b1; start_addr = addr; cycle_limit = lim; abort = ab;
        tick();
        start = 1'b0; abort = 1'b0;
        start_addr = 32'hFFFF_FFFF; cycle_limit = 32'd1;
    endtask

    // Returns during the first RUN cycle.
    task automatic wait_run();
        int n = 0;
        while (!proc_run && n < 50) begin
            tick();
            n++;
        end
        if (!proc_run) begin
            checks++;
            failures++;
            $display("FAIL wait_run_timeout actual=0 required=1");
        end
    endtask

    // Returns during the done cycle.
    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_done_timeout actual=0 required=1");
        end
    endtask

    // Assert a one-cycle input during RUN cycle k (called from RUN cycle 1).
    task automatic pulse_in_run(input int k, input logic h, input logic a);
        repeat (k - 1) tick();
        proc_halt = h; abort = a;
        tick();
        proc_halt = 1'b0; abort = 1'b0;
    endtask

    initial begin
        int dn;
        RESET = 1'b1; start = 1'b0; start_addr = 32'd0; cycle_limit = 32'd0;
        abort = 1'b0; proc_halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_proc_reset", 32'(proc_reset), 32'd1);
        check("rst_proc_run",   32'(proc_run),   32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_pc",         proc_start_pc,   32'd0);
        check("rst_run_cycles", run_cycles,      32'd0);
        check("rst_timeout",    32'(timeout),    32'd0);
        check("rst_aborted",    32'(aborted),    32'd0);
        RESET = 1'b0;

        // Halt at 10th RUN cycle, unlimited.
        push(32'h100, 32'd10, 1'b0, 1'b0, 4, 10, 2);
        do_start(32'h100, 32'd0, 1'b0);
        check("latency_busy", 32'(busy), 32'd1);
        wait_run();
        pulse_in_run(10, 1'b1, 1'b0);
        wait_done();
        tick();

        // Limit of 5, no halt.
        push(32'h200, 32'd5, 1'b1, 1'b0, 4, 5, 2);
        do_start(32'h200, 32'd5, 1'b0);
        wait_done();
        tick();

        // Halt and limit coincide on 5th cycle: halt wins.
        push(32'h300, 32'd5, 1'b0, 1'b0, 4, 5, 2);
        do_start(32'h300, 32'd5, 1'b0);
        wait_run();
        pulse_in_run(5, 1'b1, 1'b0);
        wait_done();
        tick();

        // Abort in 2nd HOLD cycle: DONE next cycle.
        push(32'h400, 32'd0, 1'b0, 1'b1, 2, 0, 0);
        do_start(32'h400, 32'd0, 1'b0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("hold_abort_done", 32'(done), 32'd1);
        wait_done();
        tick();

        // Abort together with halt on RUN cycle 3.
        push(32'h500, 32'd3, 1'b0, 1'b1, 4, 3, 2);
        do_start(32'h500, 32'd0, 1'b0);
        wait_run();
        pulse_in_run(3, 1'b1, 1'b1);
        wait_done();
        tick();

        // Start in RUN and in DONE is ignored.
        push(32'h600, 32'd7, 1'b1, 1'b0, 4, 7, 2);
        do_start(32'h600, 32'd7, 1'b0);
        wait_run();
        tick();
        start = 1'b1; start_addr = 32'hDEAD; cycle_limit = 32'd2;
        tick();
        start = 1'b0;
        wait_done();
        start = 1'b1; start_addr = 32'hBEEF; cycle_limit = 32'd9;
        tick();
        start = 1'b0;
        tick();
        check("ign_start_busy", 32'(busy),     32'd0);
        check("ign_start_pc",   proc_start_pc, 32'h600);

        // Abort in IDLE is ignored.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("idle_abort_busy",    32'(busy),    32'd0);
        check("idle_abort_aborted", 32'(aborted), 32'd0);
        check("idle_abort_timeout", 32'(timeout), 32'd1);

        // Start with abort in IDLE: start accepted, limit 3.
        push(32'h700, 32'd3, 1'b1, 1'b0, 4, 3, 2);
        do_start(32'h700, 32'd3, 1'b1);
        wait_done();
        tick();

        // Asynchronous reset in RUN cycle 3, between edges.
        do_start(32'h800, 32'd0, 1'b0);
        wait_run();
        repeat (2) tick();
        #2;
        RESET = 1'b1;
        #1;
        check("arst_proc_reset", 32'(proc_reset), 32'd1);
        check("arst_proc_run",   32'(proc_run),   32'd0);
        check("arst_busy",       32'(busy),       32'd0);
        check("arst_done",       32'(done),       32'd0);
        check("arst_pc",         proc_start_pc,   32'd0);
        check("arst_run_cycles", run_cycles,      32'd0);
        check("arst_timeout",    32'(timeout),    32'd0);
        check("arst_aborted",    32'(aborted),    32'd0);
        tick();
        RESET = 1'b0;
        dn = 0;
        repeat (12) begin
            tick();
            if (done) dn++;
        end
        check("arst_no_done", 32'(dn), 32'd0);

        // Resumes normally after reset.
        push(32'h900, 32'd2, 1'b1, 1'b0, 4, 2, 2);
        do_start(32'h900, 32'd2, 1'b0);
        wait_done();
        repeat (3) tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proc_run_controller.md
PROC_RUN_CONTROLLER -- requirements
Module: proc_run_controller

Interface
REQ-001 Parameter RESET_HOLD, default 4, number of cycles the processor is held in reset before a run (legal 1..255).
REQ-002 Parameter DRAIN_CYCLES, default 2, number of cycles with processor clock-enable low after a run ends, before completion (legal 1..255).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high controller reset.
REQ-005 start  input  1  request a run; sampled only in IDLE.
REQ-006 start_addr  input  32  processor start PC, captured on start acceptance.
REQ-007 cycle_limit  input  32  maximum RUN cycles, captured on start acceptance; 0 = unlimited.
REQ-008 abort  input  1  terminate an in-progress run.
REQ-009 proc_halt  input  1  processor reports halt; sampled only in RUN.
REQ-010 proc_reset  output  1  active-high reset to processor.
REQ-011 proc_start_pc  output  32  start PC presented to processor.
REQ-012 proc_run  output  1  processor clock-enable.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at run completion.
REQ-015 timeout  output  1  last run ended by cycle_limit; held until next start acceptance.
REQ-016 aborted  output  1  last run ended by abort; held until next start acceptance.
REQ-017 run_cycles  output  32  number of cycles proc_run was high in current/last run.

Function
REQ-018 The FSM SHALL have states IDLE, HOLD, RUN, DRAIN, DONE; all outputs SHALL be registered.
REQ-019 IDLE: proc_reset=1, proc_run=0; start=1 at an edge SHALL capture start_addr/cycle_limit, clear run_cycles/timeout/aborted, and enter HOLD.
REQ-020 HOLD SHALL last exactly RESET_HOLD cycles with proc_reset=1, proc_run=0, proc_start_pc=captured start_addr, then enter RUN.
REQ-021 RUN: proc_reset=0, proc_run=1; run_cycles SHALL increment by 1 each RUN cycle, saturating at 0xFFFFFFFF.
REQ-022 RUN SHALL exit to DRAIN at the end of the cycle in which proc_halt=1, abort=1, or run_cycles reaches a nonzero cycle_limit (i.e. exactly cycle_limit RUN cycles).
REQ-023 Exit priority SHALL be abort > proc_halt > limit; timeout set only when limit is the winning cause; aborted set only on abort.
REQ-024 DRAIN SHALL last exactly DRAIN_CYCLES cycles with proc_reset=0, proc_run=0, then enter DONE.
REQ-025 DONE SHALL last one cycle with done=1, proc_run=0, then return to IDLE (proc_reset=1 from the IDLE cycle onward).
REQ-026 abort=1 in HOLD SHALL go directly to DONE with aborted=1 and run_cycles=0; abort in DRAIN, DONE or IDLE SHALL be ignored.
REQ-027 start outside IDLE SHALL be ignored with no side effects; start and abort together in IDLE SHALL accept start.
REQ-028 start latency: start sampled at edge t gives busy=1 at t+1, first RUN cycle at t+1+RESET_HOLD.
REQ-029 proc_start_pc SHALL hold the captured value from HOLD until the next start acceptance.

Reset
REQ-030 RESET=1 SHALL immediately (asynchronously) force state IDLE, proc_reset=1, proc_run=0, proc_start_pc=0, busy=0, done=0, timeout=0, aborted=0, run_cycles=0.
REQ-031 RESET asserted mid-run SHALL abandon the run with no done pulse; operation resumes on first edge after RESET deasserts.

Verification
REQ-032 Halt run: start, start_addr=0x100, limit=0, proc_halt at 10th RUN cycle -> 4 HOLD cycles with pc=0x100, 10 cycles proc_run=1, 2 DRAIN, done pulse, run_cycles=10, timeout=0.
REQ-033 Limit run: limit=5, proc_halt never -> exactly 5 cycles proc_run=1, timeout=1, run_cycles=5; halt and limit on same 5th cycle -> timeout=0.
REQ-034 Abort: abort during HOLD -> DONE next cycle, aborted=1, run_cycles=0; abort with halt in RUN cycle 3 -> aborted=1, run_cycles=3.
REQ-035 Ignored start: start pulsed in RUN and DONE -> no state change, captured pc/limit unchanged.
REQ-036 Async reset: RESET asserted between edges in RUN -> proc_reset=1, proc_run=0 before next edge, no done, all flags 0.
